cnn_frame_feeder: RTL and testbench

- Host-side initiator for the CNN accelerator's database load/start/result interface.
- Accepts one frame of PIXELS signed samples on a valid/ready stream and writes them into the accelerator database through the we/dp/address write port.
- Then pulses GO, tracks the accelerator's STOP handshake, and returns the 4-bit classification on a valid/ready result port, with timeout protection.

---
 rtl/cnn_frame_feeder.sv | 152 +++++++++++++++
 tb/tb_cnn_frame_feeder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_frame_feeder.sv
// cnn_frame_feeder
//   Host-side initiator for the CNN accelerator database. Streams one frame of
//   PIXELS signed samples into the database write port, pulses GO, waits for
//   the STOP handshake and hands the 4-bit class back on a valid/ready port.
//   A run timer bounds the wait and reports 4'hF with a sticky error flag.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a new frame (only honoured when idle)
//   s_valid/s_data      sample stream in, s_ready = loading
//   we_database         database write strobe (one cycle after accept)
//   dp_database         database write data
//   address_p_database  database write address (START_ADDR + index)
//   GO                  one-cycle accelerator start pulse
//   STOP, RESULT        accelerator done flag (low while running) and class
//   res_valid/res_data  result out, res_ready consumes it
//   busy                frame in progress
//   timeout_err         sticky, set when the run timer saturates
module cnn_frame_feeder #(
  parameter int SIZE_1     = 11,
  parameter int ADDR_W     = 13,
  parameter int PIXELS     = 784,
  parameter int START_ADDR = 0,
  parameter int TIMEOUT_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [SIZE_1-1:0] s_data,
  output logic              s_ready,
  output logic              we_database,
  output logic [SIZE_1-1:0] dp_database,
  output logic [ADDR_W-1:0] address_p_database,
  output logic              GO,
  input  logic              STOP,
  input  logic [3:0]        RESULT,
  output logic              res_valid,
  output logic [3:0]        res_data,
  input  logic              res_ready,
  output logic              busy,
  output logic              timeout_err
);

  if (PIXELS < 1 ||
      (longint'(START_ADDR) + longint'(PIXELS)) > (longint'(1) << ADDR_W)) begin : g_param_check
    $error("cnn_frame_feeder: START_ADDR + PIXELS exceeds the database address space");
  end

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_DRAIN     = 3'd2;
  localparam logic [2:0] S_GO_PULSE  = 3'd3;
  localparam logic [2:0] S_WAIT_ACK  = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_REPORT    = 3'd6;

  localparam int              CNT_W    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(START_ADDR);

  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [CNT_W-1:0]     count;
  logic [TIMEOUT_W-1:0] timer;

  logic accept;
  logic last_accept;
  logic waiting;
  logic timer_full;
  logic capture;
  logic timeout;

  assign s_ready = (state == S_LOAD);

  always_comb begin
    accept      = s_valid && s_ready;
    last_accept = accept && (count == LAST_IDX);
    waiting     = (state == S_WAIT_ACK) || (state == S_WAIT_DONE);
    timer_full  = &timer;
    // A real STOP in the saturating cycle takes priority over the timeout.
    capture     = (state == S_WAIT_DONE) && STOP;
    timeout     = waiting && timer_full && !capture;

    next_state = state;
    case (state)
      S_IDLE:      if (start) next_state = S_LOAD;
      S_LOAD:      if (last_accept) next_state = S_DRAIN;
      S_DRAIN:     next_state = S_GO_PULSE;
      S_GO_PULSE:  next_state = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (timeout)    next_state = S_REPORT;
        else if (!STOP) next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (capture || timeout) next_state = S_REPORT;
      S_REPORT:    if (res_ready) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      count              <= '0;
      timer              <= '0;
      we_database        <= 1'b0;
      dp_database        <= '0;
      address_p_database <= '0;
      GO                 <= 1'b0;
      res_valid          <= 1'b0;
      res_data           <= '0;
      busy               <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      state       <= next_state;
      busy        <= (next_state != S_IDLE);
      we_database <= accept;
      // GO is registered off DRAIN so it lands one cycle after the last write.
      GO          <= (state == S_DRAIN);

      if (state == S_IDLE && start) begin
        count       <= '0;
        timeout_err <= 1'b0;
      end else if (accept) begin
        count <= count + 1'b1;
      end

      if (accept) begin
        dp_database        <= s_data;
        address_p_database <= BASE + ADDR_W'(count);
      end

      if (state == S_GO_PULSE) begin
        timer <= '0;
      end else if (waiting && !timer_full) begin
        timer <= timer + 1'b1;
      end

      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= RESULT;
      end else if (timeout) begin
        res_valid   <= 1'b1;
        res_data    <= 4'hF;
        timeout_err <= 1'b1;
      end else if (state == S_REPORT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_frame_feeder.sv
module tb_cnn_frame_feeder;

  localparam int SIZE_1     = 11;
  localparam int ADDR_W     = 13;
  localparam int PIXELS     = 784;
  localparam int START_ADDR = 0;
  localparam int TW         = 11;
  localparam int TMO_CYCLES = 1 << TW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [SIZE_1-1:0] s_data = '0;
  logic              s_ready;
  logic              we_database;
  logic [SIZE_1-1:0] dp_database;
  logic [ADDR_W-1:0] address_p_database;
  logic              GO;
  logic              STOP = 1'b1;
  logic [3:0]        RESULT = '0;
  logic              res_valid;
  logic [3:0]        res_data;
  logic              res_ready = 1'b0;
  logic              busy;
  logic              timeout_err;

  cnn_frame_feeder #(
    .SIZE_1    (SIZE_1),
    .ADDR_W    (ADDR_W),
    .PIXELS    (PIXELS),
    .START_ADDR(START_ADDR),
    .TIMEOUT_W (TW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .s_valid           (s_valid),
    .s_data            (s_data),
    .s_ready           (s_ready),
    .we_database       (we_database),
    .dp_database       (dp_database),
    .address_p_database(address_p_database),
    .GO                (GO),
    .STOP              (STOP),
    .RESULT            (RESULT),
    .res_valid         (res_valid),
    .res_data          (res_data),
    .res_ready         (res_ready),
    .busy              (busy),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame contents shared by the stimulus and the reference model.
  logic [SIZE_1-1:0] frame [PIXELS];

  // ---------------- reference model + per-cycle compare -------------------
  typedef enum int {M_IDLE, M_LOAD, M_DRAIN, M_GO, M_WAIT, M_REPORT} mphase_t;
  mphase_t mp = M_IDLE;
  int  n_acc = 0;
  int  waited = 0;
  bit  acked = 0;
  bit  e_we = 0, e_go = 0, e_rv = 0, e_terr = 0, e_busy = 0;
  logic [SIZE_1-1:0] e_dp = '0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [3:0]        e_rd = '0;

  int  wr_count = 0, go_count = 0, go_cyc = 0, rv_cyc = 0, first_addr = -1;
  bit  saw_7ff = 0, rv_prev = 0;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_we", we_database, 0);
        check("rst_go", GO, 0);
        check("rst_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rv", res_valid, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_dp", dp_database, 0);
        check("rst_addr", address_p_database, 0);
        check("rst_rd", res_data, 0);
        mp = M_IDLE; n_acc = 0; waited = 0; acked = 0;
        e_we = 0; e_go = 0; e_rv = 0; e_terr = 0; e_busy = 0;
        rv_prev = 0;
      end else begin
        check("s_ready", s_ready, (mp == M_LOAD));
        check("we", we_database, e_we);
        check("go", GO, e_go);
        check("res_valid", res_valid, e_rv);
        check("timeout_err", timeout_err, e_terr);
        check("busy", busy, e_busy);
        if (e_we) begin
          check("wr_addr", address_p_database, e_addr);
          check("wr_data", dp_database, e_dp);
        end
        if (e_rv) check("res_data", res_data, e_rd);

        if (we_database) begin
          wr_count++;
          if (wr_count == 1) first_addr = int'(address_p_database);
          if (address_p_database == 13'd5 && dp_database == 11'h7FF) saw_7ff = 1;
        end
        if (GO) begin go_count++; go_cyc = cyc; end
        if (res_valid && !rv_prev) rv_cyc = cyc;
        rv_prev = res_valid;

        e_we = 0;
        case (mp)
          M_IDLE:  if (start) begin mp = M_LOAD; n_acc = 0; e_terr = 0; end
          M_LOAD:  if (s_valid) begin
                     e_we   = 1;
                     e_dp   = frame[n_acc];
                     e_addr = ADDR_W'(START_ADDR + n_acc);
                     n_acc++;
                     if (n_acc == PIXELS) mp = M_DRAIN;
                   end
          M_DRAIN: mp = M_GO;
          M_GO:    begin mp = M_WAIT; waited = 0; acked = 0; end
          M_WAIT:  begin
                     if (acked && STOP) begin
                       e_rv = 1; e_rd = RESULT; mp = M_REPORT;
                     end else if (waited == TMO_CYCLES - 1) begin
                       e_rv = 1; e_rd = 4'hF; e_terr = 1; mp = M_REPORT;
                     end else begin
                       if (!STOP) acked = 1;
                       waited++;
                     end
                   end
          M_REPORT: if (res_ready) begin e_rv = 0; mp = M_IDLE; end
          default: mp = M_IDLE;
        endcase
        e_go   = (mp == M_GO);
        e_busy = (mp != M_IDLE);
      end
    end
  end

  // ---------------- accelerator stand-in ----------------------------------
  int         acc_ack = 3;
  int         acc_done = 10;
  bit         acc_never = 0;
  logic [3:0] acc_res = '0;

  initial begin : accel
    forever begin
      @(negedge clk);
      if (GO && rst_n) begin
        repeat (acc_ack) tick();
        if (!acc_never) begin
          STOP   = 1'b0;
          RESULT = ~acc_res;
          repeat (acc_done) tick();
          RESULT = acc_res;
          STOP   = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  int start_cyc = 0;

  task automatic run_frame(input int gap_pct, input bit poke, input int abort_after);
    int idx = 0;
    int guard = 0;
    bit acc;
    wr_count = 0; go_count = 0; first_addr = -1;
    start = 1'b1; start_cyc = cyc;
    tick();
    start = 1'b0;
    while (idx < PIXELS && guard < 20 * PIXELS) begin
      s_valid   = ($urandom_range(99) >= gap_pct);
      s_data    = s_valid ? frame[idx] : SIZE_1'($urandom);
      start     = poke && ($urandom_range(9) == 0);
      res_ready = poke && ($urandom_range(1) == 1);
      acc = s_valid && s_ready;
      tick();
      guard++;
      if (acc) idx++;
      if (abort_after > 0 && idx == abort_after) break;
    end
    s_valid = 1'b0; start = 1'b0; res_ready = 1'b0;
    if (abort_after == 0) check("load_complete", idx, PIXELS);
  endtask

  task automatic take_result(input int limit, input int hold, input logic [3:0] exp_rd);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (res_valid) begin ok = 1; break; end
      tick();
    end
    check("result_wait", ok, 1);
    if (ok) begin
      for (int h = 0; h < hold; h++) begin
        check("hold_valid", res_valid, 1);
        check("hold_data", res_data, exp_rd);
        tick();
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("rv_after_ready", res_valid, 0);
      check("busy_after_ready", busy, 0);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < PIXELS; i++) frame[i] = SIZE_1'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < PIXELS; i++) frame[i] = SIZE_1'($urandom);
    frame[5] = 11'h7FF;
    frame[6] = 11'h400;
  endtask

  initial begin : main
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_addr", address_p_database, 0);
    rst_n = 1'b1;
    tick();

    // Gap-free ramp, slow accelerator, start poked while running.
    fill_ramp();
    acc_ack = 3; acc_done = 1000; acc_res = 4'd7; acc_never = 0;
    run_frame(0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      start = ($urandom_range(1) == 1);
      tick();
    end
    start = 1'b0;
    take_result(2000, 5, 4'd7);
    check("A_writes", wr_count, PIXELS);
    check("A_go_count", go_count, 1);
    check("A_go_latency", go_cyc - start_cyc, PIXELS + 2);
    check("A_rv_latency", rv_cyc - go_cyc, 1004);
    check("A_first_addr", first_addr, 0);

    // Same ramp with ~30% idle cycles and start/res_ready noise during load.
    acc_ack = 2; acc_done = 20; acc_res = 4'd3;
    run_frame(30, 1, 0);
    take_result(500, 2, 4'd3);
    check("B_writes", wr_count, PIXELS);
    check("B_go_count", go_count, 1);

    // Random data incl. -1; STOP returns on the first WAIT_DONE cycle.
    fill_random();
    acc_ack = 1; acc_done = 1; acc_res = 4'd12;
    run_frame(30, 0, 0);
    take_result(500, 1, 4'd12);
    check("C_saw_7ff", saw_7ff, 1);
    check("C_writes", wr_count, PIXELS);

    // Reset after 100 samples, then a clean reload.
    fill_ramp();
    run_frame(0, 0, 100);
    check("pre_reset_we", we_database, 1);
    rst_n = 1'b0;
    #1;
    check("async_we", we_database, 0);
    check("async_go", GO, 0);
    check("async_ready", s_ready, 0);
    check("async_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    acc_ack = 4; acc_done = 30; acc_res = 4'd9;
    run_frame(0, 0, 0);
    check("D_first_addr", first_addr, 0);
    take_result(500, 0, 4'd9);
    check("D_writes", wr_count, PIXELS);

    // Accelerator never acknowledges: timeout path.
    acc_never = 1;
    fill_random();
    run_frame(10, 0, 0);
    take_result(TMO_CYCLES + 200, 3, 4'hF);
    check("T_rv_latency", rv_cyc - go_cyc, TMO_CYCLES + 1);
    check("T_terr_sticky", timeout_err, 1);

    // Next start clears the sticky error.
    acc_never = 0; acc_ack = $urandom_range(1, 5); acc_done = $urandom_range(1, 50);
    acc_res = 4'($urandom_range(0, 14));
    run_frame(30, 0, 0);
    check("E_terr_cleared", timeout_err, 0);
    take_result(500, 1, acc_res);
    check("E_writes", wr_count, PIXELS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
